imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts a raw 32-bit instruction and an immediate-format select over a valid/ready handshake. It produces the sign- or zero-extended immediate at XLEN bits, registered, with a two-entry skid buffer so that decode back-pressure never forms a combinational ready path. It supersedes the single-cycle combinational extender, adds RV64 support and shift-amount/CSR-immediate formats, and flags illegal selects with a saturating error counter.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- TAG_W, 5: width of the sideband tag (e.g. rd or ROB index) carried alongside each immediate.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input transfer request.
- in_ready  out  1  block can accept an input this cycle.
- in_instr  in  32  raw instruction word.
- in_imm_src  in  3  immediate format select.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output holds a valid result.
- out_ready  in  1  consumer accepts the output this cycle.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the output entry.
- out_illegal  out  1  output entry came from select 3'b111.
- err_clr  in  1  synchronous clear of err_count.
- err_count  out  8  count of accepted illegal selects; saturates at 255.

## Operation
- Formats (s = sign-extend from instr[31] to XLEN, z = zero-extend):
  - 000 I: s(instr[31:20]).
  - 001 S: s({instr[31:25], instr[11:7]}).
  - 010 B: s({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 011 U: s({instr[31:12], 12'b0}); for XLEN=64, bits 63:32 equal instr[31].
  - 100 J: s({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 101 I-shift: z(instr[24:20]) for XLEN=32; z(instr[25:20]) for XLEN=64.
  - 110 CSR zimm: z(instr[19:15]).
  - 111 illegal: imm = 0 and out_illegal = 1.
- Storage is one output register (OUT) plus one skid register (SKID), each holding {imm, tag, illegal, valid}.
- Accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- in_ready = !SKID.valid. This is a pure register output with no combinational path from out_ready.
- The state machine has three states, encoded by the valid bits:
  - EMPTY (OUT=0, SKID=0): an accept loads OUT, giving ONE.
  - ONE (OUT=1, SKID=0):
    - Accept with transfer: OUT reloads, staying in ONE.
    - Accept without transfer: the new entry goes to SKID, giving FULL.
    - Transfer without accept: go to EMPTY.
  - FULL (OUT=1, SKID=1): in_ready=0. A transfer moves SKID into OUT, giving ONE.
- Ordering is strictly FIFO, with no drops and no duplicates.
- err_count increments by 1 on each accept with in_imm_src=111, saturating at 255.
  - err_clr has priority: clear and increment in the same cycle yield 0.
- Inputs are sampled only on accept. in_instr, in_imm_src and in_tag are don't-care otherwise.

## Timing
- Latency is 1 cycle: an accept at edge N gives out_valid and out_imm valid after edge N.
- Sustained throughput is 1 per cycle while out_ready=1.
- out_imm, out_tag and out_illegal are stable while out_valid=1 and out_ready=0.
- out_valid does not depend combinationally on in_valid.
- Reset values, applied asynchronously on rst_n low:
  - out_valid=0, out_imm=0, out_tag=0, out_illegal=0, err_count=0.
  - SKID empty, so in_ready=1.
- Reset mid-operation discards both entries immediately. There is no output transfer in the reset cycle.
- The first accept is possible on the first rising edge after rst_n deasserts.

## Test plan
- I/S/B/J at XLEN=32, out_ready=1:
  - 0xFFF00093 sel 000 -> 0xFFFFFFFF.
  - 0xFE112E23 sel 001 -> 0xFFFFFFFC.
  - 0xFE000EE3 sel 010 -> 0xFFFFFFFC.
  - 0xFFDFF06F sel 100 -> 0xFFFFFFFC.
  - Each appears exactly 1 cycle after its accept.
- U/shift/CSR across XLEN:
  - 0x800000B7 sel 011 -> 0x80000000 at XLEN=32; 0xFFFFFFFF80000000 at XLEN=64.
  - 0x03F0D093 sel 101 -> 0x3F at XLEN=64; 0x1F at XLEN=32.
  - 0x000FD073 sel 110 -> 0x1F.
- Back-pressure:
  - Hold out_ready=0 and offer tags 1, 2, 3 back-to-back -> 1 and 2 are accepted, in_ready=0, and 3 is held.
  - Raise out_ready -> outputs appear in order 1, 2, 3, one per cycle, with no gaps after the first.
- Illegal select:
  - Sel 111 with any instr -> out_imm=0, out_illegal=1, err_count=1.
  - 260 illegal accepts -> err_count=255.
  - err_clr together with an illegal accept -> err_count=0.
- Reset mid-operation:
  - In FULL, drive rst_n low -> out_valid=0 and in_ready=1 immediately.
  - After release -> no stale entry emerges, and the next accept has 1-cycle latency.
- Random stress:
  - Random in_valid/out_ready over 10k cycles against a reference queue model.
  - Required: every accepted tag is output once, in order; out_* stay stable while stalled.

Source files
------------

// File: rtl/imm_gen_if.sv
// Decode-side handshake bundle for imm_gen_pipe: instruction in, extended immediate out,
// plus the illegal-select error counter.
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic             err_clr;
  logic [7:0]       err_count;

  modport slave (
    input  in_valid, in_instr, in_imm_src, in_tag, out_ready, err_clr,
    output in_ready, out_valid, out_imm, out_tag, out_illegal, err_count
  );

  modport master (
    output in_valid, in_instr, in_imm_src, in_tag, out_ready, err_clr,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal, err_count
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV32/RV64 immediate generator with a two-entry skid buffer so that
// in_ready never depends combinationally on out_ready.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic      clk,
  input logic      rst_n,
  imm_gen_if.slave bus
);

  typedef enum logic [2:0] {
    FMT_I   = 3'b000,
    FMT_S   = 3'b001,
    FMT_B   = 3'b010,
    FMT_U   = 3'b011,
    FMT_J   = 3'b100,
    FMT_SH  = 3'b101,
    FMT_CSR = 3'b110,
    FMT_ILL = 3'b111
  } imm_fmt_e;

  // Occupancy is carried entirely by the two valid bits: {skid.valid, out.valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
    logic             valid;
  } entry_t;

  entry_t      out_q, skid_q, new_e;
  logic [31:0] raw;
  logic        raw_illegal;
  logic        accept, xfer;
  logic [7:0]  err_q;
  state_e      state;

  // raw holds a 32-bit value whose bit 31 is the sign for every format; zero-extended
  // formats simply leave bit 31 clear, so one signed widening covers RV32 and RV64.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, or a missed
    // case arm would infer a latch.
    raw         = '0;
    raw_illegal = 1'b0;
    case (imm_fmt_e'(bus.in_imm_src))
      FMT_I:   raw = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      FMT_S:   raw = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
      FMT_B:   raw = {{20{bus.in_instr[31]}}, bus.in_instr[7], bus.in_instr[30:25],
                      bus.in_instr[11:8], 1'b0};
      FMT_U:   raw = {bus.in_instr[31:12], 12'b0};
      FMT_J:   raw = {{12{bus.in_instr[31]}}, bus.in_instr[19:12], bus.in_instr[20],
                      bus.in_instr[30:21], 1'b0};
      FMT_SH:  raw = (XLEN == 64) ? {26'b0, bus.in_instr[25:20]}
                                  : {27'b0, bus.in_instr[24:20]};
      FMT_CSR: raw = {27'b0, bus.in_instr[19:15]};
      FMT_ILL: raw_illegal = 1'b1;
      default: raw_illegal = 1'b1;
    endcase
  end

  always_comb begin
    new_e         = '0;
    new_e.imm     = XLEN'($signed(raw));
    new_e.tag     = bus.in_tag;
    new_e.illegal = raw_illegal;
    new_e.valid   = 1'b1;
  end

  assign state  = state_e'({skid_q.valid, out_q.valid});
  assign accept = bus.in_valid & ~skid_q.valid;
  assign xfer   = out_q.valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload fields are reset along with the valid bits because the
      // visible outputs (imm, tag, illegal) must read zero out of reset.
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        EMPTY: if (accept) out_q <= new_e;
        ONE: begin
          if (accept && xfer)  out_q       <= new_e;
          else if (accept)     skid_q      <= new_e;
          else if (xfer)       out_q.valid <= 1'b0;
        end
        FULL: begin
          if (xfer) begin
            out_q        <= skid_q;
            skid_q.valid <= 1'b0;
          end
        end
        default: begin
          out_q  <= '0;
          skid_q <= '0;
        end
      endcase
    end
  end

  // Clear wins over a simultaneous illegal accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      err_q <= '0;
    else if (bus.err_clr)                            err_q <= '0;
    else if (accept && new_e.illegal && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end

  assign bus.in_ready    = ~skid_q.valid;
  assign bus.out_valid   = out_q.valid;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_tag     = out_q.tag;
  assign bus.out_illegal = out_q.illegal;
  assign bus.err_count   = err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances driven in lockstep, directed
// vectors and corner sequences, then random traffic against a queue reference model.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  imm_gen_if #(.XLEN(32), .TAG_W(5)) b32 ();
  imm_gen_if #(.XLEN(64), .TAG_W(5)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [63:0] exp32;
    logic [63:0] exp64;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [4:0]  tag;
  } txn_t;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit v, logic [31:0] ins, logic [2:0] s, logic [4:0] t);
    b32.in_valid = v; b32.in_instr = ins; b32.in_imm_src = s; b32.in_tag = t;
    b64.in_valid = v; b64.in_instr = ins; b64.in_imm_src = s; b64.in_tag = t;
  endtask

  task automatic set_ready(bit r);
    b32.out_ready = r;
    b64.out_ready = r;
  endtask

  task automatic set_clr(bit c);
    b32.err_clr = c;
    b64.err_clr = c;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference immediate computed from the format rules with plain signed arithmetic.
  function automatic logic [63:0] ref_imm(logic [31:0] i, logic [2:0] s, bit x64);
    longint v;
    case (s)
      3'd0: v = longint'($signed(i[31:20]));
      3'd1: v = longint'($signed({i[31:25], i[11:7]}));
      3'd2: v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      3'd3: v = longint'($signed(i[31:12])) * 4096;
      3'd4: v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      3'd5: v = x64 ? longint'(i[25:20]) : longint'(i[24:20]);
      3'd6: v = longint'(i[19:15]);
      default: v = 0;
    endcase
    return x64 ? 64'(v) : {32'h0, v[31:0]};
  endfunction

  vec_t vecs[8];
  txn_t q[$];
  int   err_m;

  initial begin
    vecs[0] = '{32'hFFF00093, 3'b000, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1] = '{32'hFE112E23, 3'b001, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2] = '{32'hFE000EE3, 3'b010, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[3] = '{32'hFFDFF06F, 3'b100, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[4] = '{32'h800000B7, 3'b011, 64'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vecs[5] = '{32'h03F0D093, 3'b101, 64'h1F,       64'h3F,               1'b0};
    vecs[6] = '{32'h000FD073, 3'b110, 64'h1F,       64'h1F,               1'b0};
    vecs[7] = '{32'h12345678, 3'b111, 64'h0,        64'h0,                1'b1};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    set_ready(1'b1);
    set_clr(1'b0);
    repeat (3) tick();

    // Reset values.
    check("rst out_valid", b32.out_valid, 0);
    check("rst in_ready", b32.in_ready, 1);
    check("rst out_imm", b64.out_imm, 0);
    check("rst out_tag", b32.out_tag, 0);
    check("rst out_illegal", b32.out_illegal, 0);
    check("rst err_count", b32.err_count, 0);
    rst_n = 1'b1;

    // Directed vectors, back-to-back, out_ready=1: each result one cycle after its accept.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].sel, 5'(i + 1));
      tick();
      check($sformatf("vec%0d valid", i), b32.out_valid, 1);
      check($sformatf("vec%0d imm32", i), b32.out_imm, vecs[i].exp32);
      check($sformatf("vec%0d imm64", i), b64.out_imm, vecs[i].exp64);
      check($sformatf("vec%0d tag", i), b32.out_tag, 5'(i + 1));
      check($sformatf("vec%0d illegal", i), b64.out_illegal, vecs[i].ill);
    end
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    tick();
    check("illegal err_count", b32.err_count, 1);
    check("drain out_valid", b32.out_valid, 0);

    // Back-pressure: tags 1,2 accepted, 3 held, then drained in order.
    set_ready(1'b0);
    drive(1'b1, 32'h0, 3'b000, 5'd1);
    tick();
    check("bp1 tag", b32.out_tag, 1);
    check("bp1 in_ready", b32.in_ready, 1);
    drive(1'b1, 32'h0, 3'b000, 5'd2);
    tick();
    check("bp2 in_ready", b32.in_ready, 0);
    check("bp2 tag stable", b32.out_tag, 1);
    drive(1'b1, 32'h0, 3'b000, 5'd3);
    tick();
    check("bp3 in_ready", b32.in_ready, 0);
    check("bp3 tag stable", b32.out_tag, 1);
    set_ready(1'b1);
    tick();
    check("bp out2 valid", b32.out_valid, 1);
    check("bp out2 tag", b32.out_tag, 2);
    check("bp out2 in_ready", b32.in_ready, 1);
    tick();
    check("bp out3 valid", b32.out_valid, 1);
    check("bp out3 tag", b32.out_tag, 3);
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    tick();
    check("bp empty", b32.out_valid, 0);

    // Illegal saturation and clear priority.
    set_clr(1'b1);
    tick();
    set_clr(1'b0);
    check("err cleared", b32.err_count, 0);
    drive(1'b1, 32'hDEADBEEF, 3'b111, 5'd4);
    repeat (260) tick();
    check("err saturate", b32.err_count, 255);
    check("err saturate 64", b64.err_count, 255);
    set_clr(1'b1);
    tick();
    set_clr(1'b0);
    check("err clr priority", b32.err_count, 0);
    check("clr cycle illegal", b32.out_illegal, 1);
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    tick();

    // Reset mid-operation from FULL.
    set_ready(1'b0);
    drive(1'b1, 32'hFFF00093, 3'b000, 5'd5);
    tick();
    drive(1'b1, 32'hFFF00093, 3'b000, 5'd6);
    tick();
    check("pre-reset full", b32.in_ready, 0);
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async rst out_valid", b32.out_valid, 0);
    check("async rst in_ready", b32.in_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    set_ready(1'b1);
    tick();
    check("no stale entry", b32.out_valid, 0);
    drive(1'b1, 32'h00100093, 3'b000, 5'd9);
    tick();
    check("post-rst valid", b32.out_valid, 1);
    check("post-rst tag", b32.out_tag, 9);
    check("post-rst imm", b32.out_imm, 1);
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    set_clr(1'b1);
    tick();
    set_clr(1'b0);

    // Random stress against a FIFO-of-transactions model.
    err_m = 0;
    for (int c = 0; c < 10000; c++) begin
      bit          v, r, clr, exp_ready, acc;
      logic [31:0] ins;
      logic [2:0]  s;
      logic [4:0]  t;

      exp_ready = (q.size() < 2);
      check("rnd in_ready", b32.in_ready, exp_ready);
      check("rnd in_ready64", b64.in_ready, exp_ready);
      check("rnd out_valid", b32.out_valid, q.size() > 0);
      check("rnd err_count", b32.err_count, err_m);
      if (q.size() > 0) begin
        check("rnd tag", b32.out_tag, q[0].tag);
        check("rnd tag64", b64.out_tag, q[0].tag);
        check("rnd imm32", b32.out_imm, ref_imm(q[0].instr, q[0].sel, 1'b0));
        check("rnd imm64", b64.out_imm, ref_imm(q[0].instr, q[0].sel, 1'b1));
        check("rnd illegal", b32.out_illegal, q[0].sel == 3'b111);
      end
      if (fails > 20) begin
        $display("FAIL random: too many errors, stopping early");
        break;
      end

      v   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 49) == 0);
      ins = $urandom;
      s   = 3'($urandom_range(0, 7));
      t   = 5'($urandom);
      drive(v, ins, s, t);
      set_ready(r);
      set_clr(clr);

      acc = v && exp_ready;
      if (clr)                           err_m = 0;
      else if (acc && s == 3'b111 && err_m < 255) err_m++;
      if (q.size() > 0 && r) void'(q.pop_front());
      if (acc) q.push_back('{ins, s, t});
      tick();
    end

    drive(1'b0, 32'h0, 3'b000, 5'd0);
    set_clr(1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
